// File: rtl/wb_unit_if.sv
// Bundles the result-input, load-data and register-file write signals of the
// writeback unit so they can be passed around as one port.
`timescale 1ns/1ps
interface wb_unit_if #(parameter int DATA_W = 32);
  // upstream result
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_npc;
  // load data
  logic              mem_req;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  // register-file write port
  logic              reg_we;
  logic [4:0]        reg_waddr;
  logic [DATA_W-1:0] reg_wdata;

  // unit side
  modport slave (
    input  in_valid, in_op, in_rt, in_rd, in_alu, in_npc, mem_rvalid, mem_rdata,
    output in_ready, mem_req, reg_we, reg_waddr, reg_wdata
  );

  // driver side (pipeline / memory / register file)
  modport master (
    output in_valid, in_op, in_rt, in_rd, in_alu, in_npc, mem_rvalid, mem_rdata,
    input  in_ready, mem_req, reg_we, reg_waddr, reg_wdata
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: accepts one result at a time, waits for load data when
// needed (with a timeout), and issues a single register-file write.
`timescale 1ns/1ps
module wb_unit #(
  parameter int DATA_W      = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  wb_unit_if.slave    bus,
  output logic [15:0] wb_count,
  output logic        err,
  input  logic        err_clr
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // counter only needs to reach MEM_TIMEOUT-1
  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [4:0]        dest_reg, dest_next;
  logic              reg_we_reg;
  logic [4:0]        reg_waddr_reg;
  logic [DATA_W-1:0] reg_wdata_reg;
  logic [15:0]       wb_count_reg;
  logic              err_reg;

  logic [4:0]        sel_dest;
  logic              wr_go;
  logic [4:0]        wr_dest;
  logic [DATA_W-1:0] wr_data;
  logic              timeout;

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.mem_req   = (state_reg == WAIT_MEM);
  assign bus.reg_we    = reg_we_reg;
  assign bus.reg_waddr = reg_waddr_reg;
  assign bus.reg_wdata = reg_wdata_reg;
  assign wb_count      = wb_count_reg;
  assign err           = err_reg;

  // destination register chosen from the incoming opcode
  always_comb begin
    if (bus.in_op == OP_JAL)
      sel_dest = 5'd31;
    else if (bus.in_op == OP_R_FORM)
      sel_dest = bus.in_rd;
    else
      sel_dest = bus.in_rt;
  end

  // next-state logic; wr_go marks the edge that moves into WRITE
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dest_next  = dest_reg;
    wr_go      = 1'b0;
    wr_dest    = dest_reg;
    wr_data    = bus.in_alu;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          dest_next = sel_dest;
          if (bus.in_op == OP_LW) begin
            state_next = WAIT_MEM;
            cnt_next   = '0;
          end else if (bus.in_op != OP_SW && bus.in_op != OP_BEQ) begin
            state_next = WRITE;
            wr_go      = 1'b1;
            wr_dest    = sel_dest;
            wr_data    = (bus.in_op == OP_JAL) ? bus.in_npc : bus.in_alu;
          end
        end
      end
      WAIT_MEM: begin
        // data arriving in the last allowed cycle still wins over the abort
        if (bus.mem_rvalid) begin
          state_next = WRITE;
          wr_go      = 1'b1;
          wr_data    = bus.mem_rdata;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          timeout    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // state, write port and status registers; outputs for the WRITE cycle are
  // loaded on the edge entering it so reg_we is glitch-free and one cycle long
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      dest_reg      <= '0;
      reg_we_reg    <= 1'b0;
      reg_waddr_reg <= '0;
      reg_wdata_reg <= '0;
      wb_count_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dest_reg   <= dest_next;
      reg_we_reg <= wr_go && (wr_dest != 5'd0);
      if (wr_go && (wr_dest != 5'd0)) begin
        reg_waddr_reg <= wr_dest;
        reg_wdata_reg <= wr_data;
        wb_count_reg  <= wb_count_reg + 16'd1;
      end
      if (timeout)
        err_reg <= 1'b1;
      else if (err_clr)
        err_reg <= 1'b0;
    end
  end

endmodule
